dense_2_layer: RTL and testbench

Second fully-connected stage of the CNN datapath. It computes the 120→84 product with bias and ReLU. It sits directly downstream of the 400→120 dense stage and accepts that stage's packed output writes, two 16-bit activations per word. It stores the 120-entry vector, then runs two multiply-accumulate lanes against an external weight ROM and an external bias ROM. It emits one ReLU'd 16-bit result per output row to the next stage.

---
 rtl/cnn_pkg.sv | 36 +++
 rtl/dense_mac2_pipe.sv | 69 ++++++
 rtl/dense_2_layer.sv | 210 +++++++++++++++++++++
 tb/tb_dense_2_layer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN dense datapath stages.
//   FRAC_BITS / DATA_WIDTH : Q8.8 fixed-point format of activations and weights
//   dense_state_e          : FSM encoding common to all dense stages
//   sat16 / relu16         : output conditioning helpers applied at row write-back
// ----------------------------------------------------------------------------
package cnn_pkg;

    localparam int unsigned FRAC_BITS  = 8;
    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StDrain = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } dense_state_e;

    // Clamp a wide signed value into the 16-bit two's complement range.
    function automatic logic signed [15:0] sat16(input logic signed [47:0] v);
        if (v > 48'sd32767) begin
            return 16'sh7fff;
        end else if (v < -48'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    function automatic logic [15:0] relu16(input logic signed [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction

endpackage

// File: rtl/dense_mac2_pipe.sv
// ----------------------------------------------------------------------------
// dense_mac2_pipe
// Two-lane multiply-accumulate pipeline for the dense stages.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : i_x/i_w carry a valid word pair this cycle
//   i_clear    : this word pair is the first of a row; accumulator restarts
//   i_x, i_w   : packed {hi, lo} activation and weight pairs
//   o_acc      : running accumulator, updated two cycles after a valid input
// ----------------------------------------------------------------------------
module dense_mac2_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    input  logic                        i_clear,
    input  logic [2*DATA_WIDTH-1:0]     i_x,
    input  logic [2*DATA_WIDTH-1:0]     i_w,
    output logic signed [ACC_WIDTH-1:0] o_acc
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        w_x0, w_x1, w_w0, w_w1;
    logic signed [PW-1:0]        w_p0, w_p1;
    logic signed [PW-1:0]        r_p0, r_p1;
    logic                        r_pv, r_pclr;
    logic signed [ACC_WIDTH-1:0] r_acc, w_acc_d;

    // Sign-extend operands to product width so the full product is kept.
    assign w_x0 = {{DATA_WIDTH{i_x[DATA_WIDTH-1]}}, i_x[DATA_WIDTH-1:0]};
    assign w_x1 = {{DATA_WIDTH{i_x[PW-1]}}, i_x[PW-1:DATA_WIDTH]};
    assign w_w0 = {{DATA_WIDTH{i_w[DATA_WIDTH-1]}}, i_w[DATA_WIDTH-1:0]};
    assign w_w1 = {{DATA_WIDTH{i_w[PW-1]}}, i_w[PW-1:DATA_WIDTH]};

    assign w_p0 = w_x0 * w_w0;
    assign w_p1 = w_x1 * w_w1;

    // Clear folds into the first accumulate so back-to-back rows need no bubble.
    always_comb begin
        w_acc_d = (r_pclr ? '0 : r_acc)
                + {{(ACC_WIDTH-PW){r_p0[PW-1]}}, r_p0}
                + {{(ACC_WIDTH-PW){r_p1[PW-1]}}, r_p1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0   <= '0;
            r_p1   <= '0;
            r_pv   <= 1'b0;
            r_pclr <= 1'b0;
            r_acc  <= '0;
        end else begin
            r_pv   <= i_valid;
            r_pclr <= i_clear;
            if (i_valid) begin
                r_p0 <= w_p0;
                r_p1 <= w_p1;
            end
            if (r_pv) begin
                r_acc <= w_acc_d;
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dense_2_layer.sv
// ----------------------------------------------------------------------------
// dense_2_layer
// 120->84 fully-connected stage with bias and ReLU, Q8.8 arithmetic.
//   clk, rst_n            : clock, asynchronous active-low reset
//   layer_enable          : start request, honoured only while idle
//   wr_en/wr_addr/wr_data : packed input vector writes {x[2a+1], x[2a]}
//   in_ready              : high while idle (writes accepted)
//   weight_addr/_data     : external weight ROM, 1-cycle read latency
//   bias_addr/_data       : external bias ROM, 1-cycle read latency
//   out_wr_en/addr/data   : one write per output row
//   layer_done            : one-cycle pulse after the last row
// Row period is IN_WORDS issue cycles + 3 drain cycles + 1 write cycle.
// ----------------------------------------------------------------------------
module dense_2_layer #(
    parameter int unsigned IN_LEN     = 120,
    parameter int unsigned OUT_LEN    = 84,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    layer_enable,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    output logic                    in_ready,
    output logic [ADDR_WIDTH-1:0]   weight_addr,
    input  logic [2*DATA_WIDTH-1:0] weight_data,
    output logic [ADDR_WIDTH-1:0]   bias_addr,
    input  logic [DATA_WIDTH-1:0]   bias_data,
    output logic                    out_wr_en,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    layer_done
);

    import cnn_pkg::*;

    localparam int unsigned IN_WORDS  = IN_LEN / 2;
    localparam int unsigned IDX_W     = $clog2(IN_WORDS);
    localparam int unsigned ACC_WIDTH = 40;
    localparam int unsigned SUM_WIDTH = 48;

    localparam logic [ADDR_WIDTH-1:0] IN_WORDS_A = ADDR_WIDTH'(IN_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(IN_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = ADDR_WIDTH'(OUT_LEN - 1);

    dense_state_e r_state, w_state_next;

    logic [ADDR_WIDTH-1:0]   r_row, r_word;
    logic [1:0]              r_drain;
    logic [2*DATA_WIDTH-1:0] r_buf [IN_WORDS];
    logic [2*DATA_WIDTH-1:0] r_x;
    logic                    r_iss_v, r_iss_first;
    logic [ADDR_WIDTH-1:0]   r_out_addr;
    logic [DATA_WIDTH-1:0]   r_out_data;

    logic                        w_idle, w_issue, w_write, w_done;
    logic                        w_buf_we, w_drain_last;
    logic signed [ACC_WIDTH-1:0] w_acc;
    logic signed [SUM_WIDTH-1:0] w_sum, w_shift;
    logic [DATA_WIDTH-1:0]       w_res;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (layer_enable) w_state_next = StIssue;
            StIssue: if (r_word == LAST_WORD) w_state_next = StDrain;
            StDrain: if (r_drain == 2'd2) w_state_next = StWrite;
            StWrite: w_state_next = (r_row == LAST_ROW) ? StDone : StIssue;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_idle  = 1'b0;
        w_issue = 1'b0;
        w_write = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            StIdle:  w_idle  = 1'b1;
            StIssue: w_issue = 1'b1;
            StWrite: w_write = 1'b1;
            StDone:  w_done  = 1'b1;
            default: ;
        endcase
    end

    assign w_drain_last = (r_state == StDrain) && (r_drain == 2'd2);

    // ------------------------------------------------------------------
    // Row / word / drain counters and issue-side pipeline flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_word      <= '0;
            r_drain     <= '0;
            r_iss_v     <= 1'b0;
            r_iss_first <= 1'b0;
        end else begin
            // Flags travel alongside the buffer/ROM read data.
            r_iss_v     <= w_issue;
            r_iss_first <= w_issue && (r_word == '0);
            unique case (r_state)
                StIdle: begin
                    if (layer_enable) begin
                        r_row  <= '0;
                        r_word <= '0;
                    end
                end
                StIssue: begin
                    r_word  <= r_word + 1'b1;
                    r_drain <= '0;
                end
                StDrain: begin
                    r_drain <= r_drain + 1'b1;
                end
                StWrite: begin
                    if (r_row != LAST_ROW) begin
                        r_row  <= r_row + 1'b1;
                        r_word <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Input vector buffer (not reset) and its registered read port
    // ------------------------------------------------------------------
    assign w_buf_we = w_idle && wr_en && (wr_addr < IN_WORDS_A);

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        r_x <= r_buf[r_word[IDX_W-1:0]];
    end

    // ------------------------------------------------------------------
    // MAC lanes
    // ------------------------------------------------------------------
    dense_mac2_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_iss_v),
        .i_clear (r_iss_first),
        .i_x     (r_x),
        .i_w     (weight_data),
        .o_acc   (w_acc)
    );

    // ------------------------------------------------------------------
    // Bias add, rescale, saturate, ReLU. The accumulator is final during
    // the last drain cycle, so results are captured on that edge and are
    // presented during the WRITE cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = {{(SUM_WIDTH-ACC_WIDTH){w_acc[ACC_WIDTH-1]}}, w_acc}
              + ({{(SUM_WIDTH-DATA_WIDTH){bias_data[DATA_WIDTH-1]}}, bias_data} << FRAC_BITS);
        w_shift = w_sum >>> FRAC_BITS;
        w_res   = relu16(sat16(w_shift));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_addr <= '0;
            r_out_data <= '0;
        end else if (w_drain_last) begin
            r_out_addr <= r_row;
            r_out_data <= w_res;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = w_idle;
    assign weight_addr = r_row * IN_WORDS_A + r_word;
    assign bias_addr   = r_row;
    assign out_wr_en   = w_write;
    assign out_addr    = r_out_addr;
    assign out_data    = r_out_data;
    assign layer_done  = w_done;

endmodule

// File: tb/tb_dense_2_layer.sv
module tb_dense_2_layer;

    localparam int IN_WORDS = 60;
    localparam int OUT_LEN  = 84;
    localparam int P        = IN_WORDS + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        layer_enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        in_ready;
    logic [15:0] weight_addr;
    logic [31:0] weight_data = '0;
    logic [15:0] bias_addr;
    logic [15:0] bias_data = '0;
    logic        out_wr_en;
    logic [15:0] out_addr;
    logic [15:0] out_data;
    logic        layer_done;

    int mode = 1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dense_2_layer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .layer_enable (layer_enable),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .in_ready     (in_ready),
        .weight_addr  (weight_addr),
        .weight_data  (weight_data),
        .bias_addr    (bias_addr),
        .bias_data    (bias_data),
        .out_wr_en    (out_wr_en),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .layer_done   (layer_done)
    );

    // Input vector word a for each test pattern.
    function automatic logic [31:0] x_model(input int m, input int a);
        case (m)
            1:       return 32'h0100_0100;
            2:       return 32'h0200_0200;
            3:       return 32'h0100_0100;
            4:       return (a == 5) ? 32'h0080_0180 : 32'h0000_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] w_model(input int m, input logic [15:0] addr);
        int r;
        int w;
        r = int'(addr) / IN_WORDS;
        w = int'(addr) % IN_WORDS;
        case (m)
            1:       return 32'h0100_0100;
            2:       return 32'h0200_0200;
            3:       return 32'hFF00_FF00;
            4:       return (w == 5) ? {16'(r * 256), 16'(r * 256)} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [15:0] b_model(input int m);
        case (m)
            3:       return 16'h0100;
            4:       return 16'h0040;
            default: return 16'h0000;
        endcase
    endfunction

    // Hand-derived results: 120*1.0=120.0; 120*4.0 saturates; -120+1 -> ReLU 0;
    // sparse: 1.5r+0.5r+0.25 = 2r+0.25, saturating once r >= 64.
    function automatic logic [15:0] exp_out(input int m, input int r);
        case (m)
            1:       return 16'h7800;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            4:       return (r < 64) ? 16'(r * 512 + 64) : 16'h7FFF;
            default: return 16'h0000;
        endcase
    endfunction

    // Registered ROMs, one-cycle latency.
    always @(posedge clk) begin
        weight_data <= w_model(mode, weight_addr);
        bias_data   <= b_model(mode);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_wr_en"}, 32'(out_wr_en), 32'd0);
        check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_layer_done"}, 32'(layer_done), 32'd0);
        check({tag, "_weight_addr"}, 32'(weight_addr), 32'd0);
        check({tag, "_bias_addr"}, 32'(bias_addr), 32'd0);
    endtask

    // Loads a full vector, then tries out-of-range writes that alias word 5/0
    // if the range check were missing.
    task automatic load(input int m);
        mode = m;
        for (int a = 0; a < IN_WORDS; a++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 16'(a);
            wr_data = x_model(m, a);
        end
        @(negedge clk);
        wr_addr = 16'd69;
        wr_data = 32'h7FFF_7FFF;
        @(negedge clk);
        wr_addr = 16'd64;
        @(negedge clk);
        wr_addr = 16'hFFFF;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input int m, input bit disturb, input bit late_wr);
        int  row;
        bit  done_seen;
        row       = 0;
        done_seen = 1'b0;
        mode      = m;
        @(negedge clk);
        layer_enable = 1'b1;
        if (late_wr) begin
            wr_en   = 1'b1;
            wr_addr = 16'd5;
            wr_data = x_model(m, 5);
        end
        @(negedge clk);
        layer_enable = 1'b0;
        wr_en        = 1'b0;
        for (int cyc = 0; cyc <= P * OUT_LEN + 1; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (disturb && cyc == 100) begin
                check("in_ready_busy", 32'(in_ready), 32'd0);
                wr_en        = 1'b1;
                wr_addr      = 16'd0;
                wr_data      = 32'h8000_8000;
                layer_enable = 1'b1;
            end
            if (disturb && cyc == 101) begin
                wr_en        = 1'b0;
                layer_enable = 1'b0;
            end
            if (out_wr_en) begin
                check("wr_cycle", 32'(cyc), 32'(row * P + IN_WORDS + 3));
                check("out_addr", 32'(out_addr), 32'(row));
                check("out_data", 32'(out_data), 32'(exp_out(m, row)));
                row++;
            end
            if (layer_done) begin
                check("done_cycle", 32'(cyc), 32'(P * OUT_LEN));
                done_seen = 1'b1;
            end
        end
        check("in_ready_end", 32'(in_ready), 32'd1);
        check("rows_written", 32'(row), 32'(OUT_LEN));
        check("done_seen", 32'(done_seen), 32'd1);
    endtask

    initial begin
        int pulses;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1.0 * 1.0 over 120 terms, with writes and enable injected mid-run
        load(1);
        run(1, 1'b1, 1'b0);
        // Same vector reused without reloading
        run(1, 1'b0, 1'b0);

        // Saturation
        load(2);
        run(2, 1'b0, 1'b0);

        // Negative sum, ReLU clamps to zero
        load(3);
        run(3, 1'b0, 1'b0);

        // Sparse vector; word 5 corrected in the same cycle as layer_enable
        load(4);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 16'd5;
        wr_data = 32'h7FFF_7FFF;
        @(negedge clk);
        wr_en = 1'b0;
        run(4, 1'b0, 1'b1);

        // Reset in the middle of a run
        load(1);
        @(negedge clk);
        layer_enable = 1'b1;
        @(negedge clk);
        layer_enable = 1'b0;
        repeat (1000) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_wr_en || layer_done) pulses++;
        end
        check("no_pulse_after_reset", 32'(pulses), 32'd0);

        // Reload and restart after the abort
        load(1);
        run(1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
